// File: rtl/rc4_nibble_ctrl.sv
// RC4 sequencer for 4-bit words: owns the 16x4 S array and the key store,
// and runs identity init, KSA and PRGA, streaming keystream over valid/ready.
module rc4_nibble_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_wr,
  input  logic [3:0] key_addr,
  input  logic [3:0] key_data,
  input  logic [3:0] key_len,
  input  logic       start,
  input  logic       abort,
  input  logic       ks_ready,
  output logic [3:0] ks_out,
  output logic       ks_valid,
  output logic       busy,
  output logic       ksa_done
);

  typedef enum logic [3:0] {
    IDLE, INIT, KSA_J, KSA_SWAP, PRG_I, PRG_J, PRG_SWAP, PRG_OUT, PRG_WAIT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] i_q, i_d;
  logic [3:0] j_q, j_d;
  logic [3:0] k_q, k_d;
  logic [3:0] klast_q, klast_d;
  logic [3:0] ks_out_q, ks_out_d;
  logic       ks_valid_q, ks_valid_d;
  logic       ksa_done_q, ksa_done_d;
  logic [3:0] s_q   [16];
  logic [3:0] s_d   [16];
  logic [3:0] key_q [16];
  logic [3:0] key_d [16];
  logic [3:0] out_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      klast_q    <= '0;
      ks_out_q   <= '0;
      ks_valid_q <= 1'b0;
      ksa_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      klast_q    <= klast_d;
      ks_out_q   <= ks_out_d;
      ks_valid_q <= ks_valid_d;
      ksa_done_q <= ksa_done_d;
    end
  end

  // Storage arrays are deliberately left out of reset; contents are rebuilt by INIT.
  always_ff @(posedge clk) begin
    s_q   <= s_d;
    key_q <= key_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (start) state_d = INIT;
        INIT:     if (i_q == 4'd15) state_d = KSA_J;
        KSA_J:    state_d = KSA_SWAP;
        KSA_SWAP: state_d = (i_q == 4'd15) ? PRG_I : KSA_J;
        PRG_I:    state_d = PRG_J;
        PRG_J:    state_d = PRG_SWAP;
        PRG_SWAP: state_d = PRG_OUT;
        PRG_OUT:  state_d = PRG_WAIT;
        PRG_WAIT: if (ks_valid_q && ks_ready) state_d = PRG_I;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    klast_d    = klast_q;
    ks_out_d   = ks_out_q;
    ks_valid_d = ks_valid_q;
    ksa_done_d = ksa_done_q;
    s_d        = s_q;
    key_d      = key_q;
    out_idx    = s_q[i_q] + s_q[j_q];
    case (state_q)
      IDLE: begin
        if (key_wr) key_d[key_addr] = key_data;
        if (start) begin
          i_d     = '0;
          k_d     = '0;
          // len-1 in 4 bits maps key_len=0 onto 15, i.e. a 16-nibble key.
          klast_d = key_len - 4'd1;
        end
      end
      INIT: begin
        s_d[i_q] = i_q;
        i_d      = i_q + 4'd1;
        if (i_q == 4'd15) begin
          j_d = '0;
          k_d = '0;
        end
      end
      KSA_J: j_d = j_q + s_q[i_q] + key_q[k_q];
      KSA_SWAP: begin
        s_d[i_q] = s_q[j_q];
        s_d[j_q] = s_q[i_q];
        k_d      = (k_q == klast_q) ? 4'd0 : k_q + 4'd1;
        i_d      = i_q + 4'd1;
        if (i_q == 4'd15) begin
          j_d        = '0;
          ksa_done_d = 1'b1;
        end
      end
      PRG_I: i_d = i_q + 4'd1;
      PRG_J: j_d = j_q + s_q[i_q];
      PRG_SWAP: begin
        s_d[i_q] = s_q[j_q];
        s_d[j_q] = s_q[i_q];
      end
      PRG_OUT: begin
        ks_out_d   = s_q[out_idx];
        ks_valid_d = 1'b1;
      end
      PRG_WAIT: if (ks_valid_q && ks_ready) ks_valid_d = 1'b0;
      default: ;
    endcase
    if (abort) begin
      ks_valid_d = 1'b0;
      ksa_done_d = 1'b0;
    end
  end

  assign ks_out   = ks_out_q;
  assign ks_valid = ks_valid_q;
  assign ksa_done = ksa_done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_rc4_nibble_ctrl.sv
// Self-checking bench for rc4_nibble_ctrl against a plain-arithmetic RC4 model.
module tb_rc4_nibble_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_wr;
  logic [3:0] key_addr;
  logic [3:0] key_data;
  logic [3:0] key_len;
  logic       start;
  logic       abort;
  logic       ks_ready;
  logic [3:0] ks_out;
  logic       ks_valid;
  logic       busy;
  logic       ksa_done;

  rc4_nibble_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .key_wr   (key_wr),
    .key_addr (key_addr),
    .key_data (key_data),
    .key_len  (key_len),
    .start    (start),
    .abort    (abort),
    .ks_ready (ks_ready),
    .ks_out   (ks_out),
    .ks_valid (ks_valid),
    .busy     (busy),
    .ksa_done (ksa_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int key_m [16];
  int exp_q [$];
  int got_q [$];
  int got_t [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_key(input int a, input int d);
    key_wr   = 1'b1;
    key_addr = 4'(a);
    key_data = 4'(d);
    wait_edges(1);
    key_wr   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    wait_edges(1);
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    wait_edges(1);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ksa_done", {31'd0, ksa_done}, 32'd0);
    check("abort_ks_valid", {31'd0, ks_valid}, 32'd0);
  endtask

  // Textbook RC4 over 4-bit words; fills exp_q with n keystream nibbles.
  task automatic build_model(input int len, input int n);
    int s [16];
    int j, t, ii;
    for (int x = 0; x < 16; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 16; x++) begin
      j = (j + s[x] + key_m[x % len]) % 16;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    exp_q.delete();
    ii = 0;
    j  = 0;
    for (int x = 0; x < n; x++) begin
      ii = (ii + 1) % 16;
      j  = (j + s[ii]) % 16;
      t = s[ii]; s[ii] = s[j]; s[j] = t;
      exp_q.push_back(s[(s[ii] + s[j]) % 16]);
    end
  endtask

  // Drains n nibbles; ready is random or forced high. Checks ks_out stays
  // put while a nibble waits unaccepted.
  task automatic collect(input int n, input bit rnd, input int budget);
    int   cyc = 0;
    logic pv  = 1'b0;
    logic pr  = 1'b0;
    logic [3:0] po = '0;
    got_q.delete();
    got_t.delete();
    while (cyc < budget && got_q.size() < n) begin
      if (pv && !pr) begin
        check("hold_valid", {31'd0, ks_valid}, 32'd1);
        check("hold_data", {28'd0, ks_out}, {28'd0, po});
      end
      ks_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ks_valid && ks_ready) begin
        got_q.push_back(int'(ks_out));
        got_t.push_back(cyc);
      end
      pv = ks_valid;
      pr = ks_ready;
      po = ks_out;
      wait_edges(1);
      cyc++;
    end
    ks_ready = 1'b0;
    check("collect_count", got_q.size(), n);
  endtask

  task automatic first_valid(output int e_valid, output int e_done);
    e_valid = 0;
    e_done  = -1;
    while (!ks_valid && e_valid < 70) begin
      wait_edges(1);
      e_valid++;
      if (ksa_done && e_done < 0) e_done = e_valid;
    end
  endtask

  initial begin
    int ev, ed, a, lim;
    rst = 1'b1; key_wr = 1'b0; key_addr = '0; key_data = '0; key_len = '0;
    start = 1'b0; abort = 1'b0; ks_ready = 1'b0;
    wait_edges(3);
    check("rst_ks_out", {28'd0, ks_out}, 32'd0);
    check("rst_ks_valid", {31'd0, ks_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ksa_done", {31'd0, ksa_done}, 32'd0);
    rst = 1'b0;
    wait_edges(2);

    // Single zero nibble key, ready held high.
    write_key(0, 0);
    key_m[0] = 0;
    key_len  = 4'd1;
    ks_ready = 1'b1;
    do_start();
    check("busy_edge0", {31'd0, busy}, 32'd1);
    first_valid(ev, ed);
    check("zero_ksa_done_edge", ed, 48);
    check("zero_first_valid_edge", ev, 52);
    collect(3, 1'b0, 40);
    build_model(1, 3);
    if (got_q.size() == 3) begin
      check("zero_ks0", got_q[0], 8);
      check("zero_ks1", got_q[1], 15);
      check("zero_ks2", got_q[2], 6);
      for (int x = 0; x < 3; x++) check("zero_model", got_q[x], exp_q[x]);
      check("zero_gap01", got_t[1] - got_t[0], 5);
      check("zero_gap12", got_t[2] - got_t[1], 5);
    end
    do_abort();

    // Backpressure with the same key.
    ks_ready = 1'b0;
    do_start();
    first_valid(ev, ed);
    check("bp_first_valid_edge", ev, 52);
    for (int x = 0; x < 10; x++) begin
      wait_edges(1);
      check("bp_hold_out", {28'd0, ks_out}, 32'd8);
      check("bp_hold_valid", {31'd0, ks_valid}, 32'd1);
    end
    collect(2, 1'b0, 30);
    if (got_q.size() == 2) begin
      check("bp_ks0", got_q[0], 8);
      check("bp_ks1", got_q[1], 15);
      check("bp_gap", got_t[1] - got_t[0], 5);
    end
    do_abort();

    // 16-nibble random key, stray key write during KSA.
    key_len = 4'd0;
    for (int x = 0; x < 16; x++) begin
      key_m[x] = $urandom_range(0, 15);
      write_key(x, key_m[x]);
    end
    build_model(16, 200);
    do_start();
    wait_edges(24);
    a = $urandom_range(0, 15);
    write_key(a, key_m[a] ^ 15);
    collect(200, 1'b1, 4000);
    lim = (got_q.size() < 200) ? got_q.size() : 200;
    for (int x = 0; x < lim; x++) check("rand_stream", got_q[x], exp_q[x]);
    do_abort();

    // Abort at KSA edge 30 with an ignored start at edge 10, then restart.
    do_start();
    wait_edges(9);
    start   = 1'b1;
    key_len = 4'd3;
    wait_edges(1);
    start   = 1'b0;
    key_len = 4'd0;
    wait_edges(19);
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    do_abort();
    abort = 1'b1;
    start = 1'b1;
    wait_edges(1);
    abort = 1'b0;
    start = 1'b0;
    check("abort_over_start", {31'd0, busy}, 32'd0);
    do_start();
    collect(30, 1'b1, 800);
    lim = (got_q.size() < 30) ? got_q.size() : 30;
    for (int x = 0; x < lim; x++) check("restart_stream", got_q[x], exp_q[x]);

    // Asynchronous reset in the middle of PRGA.
    ks_ready = 1'b0;
    wait_edges(8);
    check("pre_rst_ksa_done", {31'd0, ksa_done}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_ks_out", {28'd0, ks_out}, 32'd0);
    check("async_ks_valid", {31'd0, ks_valid}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_ksa_done", {31'd0, ksa_done}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_edges(3);
    check("idle_after_rst_busy", {31'd0, busy}, 32'd0);
    check("idle_after_rst_valid", {31'd0, ks_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
